instr_issue_queue: RTL and testbench

In-order instruction issue buffer that feeds the Tomasulo core's `instr` input and reacts to its `A_stall`/`LS_stall` back-pressure. An upstream loader, such as a testbench or instruction memory, pushes 32-bit RV32 instructions through a valid/ready handshake. The queue presents the head instruction to the core and holds it while the matching stall is asserted. It pops the instruction on the cycle it is accepted and drives a bubble (`32'h00000000`, which decodes to no enables) when it has nothing to issue.

---
 rtl/instr_issue_queue.sv | 105 ++++++++++
 tb/tb_instr_issue_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// In-order instruction issue buffer in front of the Tomasulo core.
// Presents the head instruction and pops it when accepted or dropped.
module instr_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    input  logic             A_stall,
    input  logic             LS_stall,
    output logic [31:0]      instr,
    output logic             issued,
    output logic             dropped,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic [15:0]      stall_cycles
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_stall_cycles;

    logic [31:0] w_head_instr;
    logic [6:0]  w_opcode;
    logic        w_is_a;
    logic        w_is_ls;
    logic        w_push;
    logic        w_pop;
    logic        w_blocked;

    // Head decode and issue decision, all from registered state plus stalls.
    always_comb begin
        w_head_instr = r_mem[r_head];
        w_opcode     = w_head_instr[6:0];
        w_is_ls      = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);
        w_is_a       = (w_opcode == OP_R)    || (w_opcode == OP_I);

        empty        = (r_count == '0);
        full         = (r_count == CNT_W'(DEPTH));
        in_ready     = !full;
        count        = r_count;
        stall_cycles = r_stall_cycles;

        instr   = empty ? 32'h0000_0000 : w_head_instr;
        issued  = !flush && !empty &&
                  ((w_is_a && !A_stall) || (w_is_ls && !LS_stall));
        dropped = !flush && !empty && !w_is_a && !w_is_ls;

        w_push    = in_valid && !full && !flush && !reset;
        w_pop     = issued || dropped;
        w_blocked = !empty && !issued && !dropped;
    end

    // Storage is not reset; empty forces the bubble on instr.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_blocked) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_instr_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [31:0] ADD = 32'h0020_8033;
    localparam logic [31:0] LW  = 32'h0001_2083;
    localparam logic [31:0] JAL = 32'h0000_006F;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             flush;
    logic             A_stall;
    logic             LS_stall;
    logic [31:0]      instr;
    logic             issued;
    logic             dropped;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic [15:0]      stall_cycles;

    instr_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .A_stall(A_stall), .LS_stall(LS_stall),
        .instr(instr), .issued(issued), .dropped(dropped), .count(count),
        .empty(empty), .full(full), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] mq[$];
    logic [15:0] m_stall = 16'd0;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // 0 = unsupported, 1 = arithmetic class, 2 = load/store class
    function automatic int op_class(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011: return 1;
            7'b0000011, 7'b0100011: return 2;
            default:                return 0;
        endcase
    endfunction

    // One clock cycle: drive, compare against model, then advance the model.
    task automatic cyc(input bit rst, input bit fl, input bit v, input logic [31:0] ins,
                       input bit as, input bit ls, output bit acc);
        logic [31:0] e_instr;
        bit e_empty, e_full, e_iss, e_drop;
        int c;
        @(negedge clk);
        reset = rst; flush = fl; in_valid = v; in_instr = ins; A_stall = as; LS_stall = ls;
        #1;
        e_empty = (mq.size() == 0);
        e_full  = (mq.size() == DEPTH);
        e_instr = e_empty ? 32'h0 : mq[0];
        c       = e_empty ? 0 : op_class(e_instr);
        e_iss   = !fl && !e_empty && ((c == 1 && !as) || (c == 2 && !ls));
        e_drop  = !fl && !e_empty && (c == 0);
        acc     = v && !rst && !fl && !e_full;
        if (m_valid) begin
            chk("instr",        instr,              e_instr);
            chk("issued",       32'(issued),        32'(e_iss));
            chk("dropped",      32'(dropped),       32'(e_drop));
            chk("count",        32'(count),         32'(mq.size()));
            chk("empty",        32'(empty),         32'(e_empty));
            chk("full",         32'(full),          32'(e_full));
            chk("in_ready",     32'(in_ready),      32'(!e_full));
            chk("stall_cycles", 32'(stall_cycles),  32'(m_stall));
        end
        if (rst) begin
            mq.delete();
            m_stall = 16'd0;
            m_valid = 1'b1;
        end else begin
            if (!e_empty && !e_iss && !e_drop) m_stall = m_stall + 16'd1;
            if (fl) mq.delete();
            else begin
                if (e_iss || e_drop) void'(mq.pop_front());
                if (acc) mq.push_back(ins);
            end
        end
    endtask

    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1101111, 7'b1100011, 7'b0110111};

    initial begin
        bit a;
        int k;
        logic [31:0] r;
        logic [31:0] w;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        A_stall = 1'b0; LS_stall = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, a);

        // Basic fill and drain
        cyc(0, 0, 1, ADD, 0, 0, a);
        cyc(0, 0, 1, LW, 0, 0, a);
        chk("basic_c2_instr", instr, ADD);
        chk("basic_c2_issued", 32'(issued), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, a);
        chk("basic_c3_instr", instr, LW);
        chk("basic_c3_issued", 32'(issued), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, a);
        chk("basic_drained_instr", instr, 32'h0);
        chk("basic_drained_empty", 32'(empty), 32'd1);

        // Class-specific stall
        cyc(1, 0, 0, 0, 0, 0, a);
        cyc(0, 0, 1, LW, 0, 0, a);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, a);
        chk("ls_stall_issued", 32'(issued), 32'd0);
        cyc(0, 0, 0, 0, 1, 0, a);
        chk("ls_stall_count3", 32'(stall_cycles), 32'd3);
        chk("ls_other_stall_issue", 32'(issued), 32'd1);
        chk("ls_other_stall_instr", instr, LW);

        // Full and wrap
        cyc(1, 0, 0, 0, 0, 0, a);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, ADD | (32'(i) << 7), 1, 0, a);
        cyc(0, 0, 1, ADD | (32'd8 << 7), 1, 0, a);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_ninth_rejected", 32'(a), 32'd0);
        k = 8;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, ADD | (32'(k % 32) << 7), 0, 0, a);
            if (a) k++;
        end

        // Unsupported opcode
        cyc(1, 0, 0, 0, 0, 0, a);
        cyc(0, 0, 1, JAL, 0, 0, a);
        cyc(0, 0, 1, ADD, 0, 0, a);
        chk("jal_dropped", 32'(dropped), 32'd1);
        chk("jal_not_issued", 32'(issued), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, a);
        chk("jal_next_head", instr, ADD);

        // Flush, then reset while full and stalled
        cyc(1, 0, 0, 0, 0, 0, a);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, ADD, 1, 0, a);
        cyc(0, 1, 1, LW, 1, 0, a);
        cyc(0, 0, 0, 0, 0, 0, a);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_instr", instr, 32'h0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, LW, 0, 1, a);
        cyc(1, 0, 0, 0, 0, 1, a);
        cyc(0, 0, 0, 0, 0, 1, a);
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            w = {r[31:7], ops[$urandom_range(0, 6)]};
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 9) < 7), w,
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
